// File: rtl/switch_hit_detector.sv
// Synchronizes and debounces eight slide switches, then judges one flip per LED step as hit/miss.
// Define SWITCH_MISS_EN to pulse miss on wrong flips; otherwise miss is 0 and wrong flips are ignored.
module switch_hit_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] switch,
  input  logic [7:0] led_state,
  input  logic       led_step,
  output logic [7:0] sw_clean,
  output logic       armed,
  output logic       hit,
  output logic       miss
);

  localparam int unsigned NSW   = 8;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  logic [NSW-1:0]   sync1_q, sync2_q;
  logic [NSW-1:0]   clean_q, clean_d;
  logic [NSW-1:0]   clean_dly_q;
  logic [CNT_W-1:0] cnt_q [NSW];
  logic [CNT_W-1:0] cnt_d [NSW];
  logic [NSW-1:0]   ev;
  state_e           state_q, state_d;
  logic             hit_q, hit_d;
  logic             armed_q, armed_d;
`ifdef SWITCH_MISS_EN
  logic             miss_q, miss_d;
`endif

  function automatic logic is_onehot(input logic [NSW-1:0] v);
    return (v != '0) && ((v & (v - NSW'(1))) == '0);
  endfunction

  // Per-bit debounce: accept a new level only after it has held for DEBOUNCE_CYCLES.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < NSW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign ev = clean_q ^ clean_dly_q;

  // Judge one event per step; a concurrent led_step discards the event.
  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
`ifdef SWITCH_MISS_EN
    miss_d  = 1'b0;
`endif
    if (led_step) begin
      state_d = ARMED;
    end else if ((state_q == ARMED) && (ev != '0)) begin
      if (is_onehot(ev) && (ev == led_state)) begin
        hit_d   = 1'b1;
        state_d = DONE;
      end
`ifdef SWITCH_MISS_EN
      else begin
        miss_d  = 1'b1;
        state_d = DONE;
      end
`endif
    end
    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      clean_q     <= '0;
      clean_dly_q <= '0;
      for (int i = 0; i < NSW; i++) cnt_q[i] <= '0;
      state_q     <= IDLE;
      hit_q       <= 1'b0;
      armed_q     <= 1'b0;
`ifdef SWITCH_MISS_EN
      miss_q      <= 1'b0;
`endif
    end else begin
      sync1_q     <= switch;
      sync2_q     <= sync1_q;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      for (int i = 0; i < NSW; i++) cnt_q[i] <= cnt_d[i];
      state_q     <= state_d;
      hit_q       <= hit_d;
      armed_q     <= armed_d;
`ifdef SWITCH_MISS_EN
      miss_q      <= miss_d;
`endif
    end
  end

  assign sw_clean = clean_q;
  assign armed    = armed_q;
  assign hit      = hit_q;
`ifdef SWITCH_MISS_EN
  assign miss     = miss_q;
`else
  assign miss     = 1'b0;
`endif

endmodule

// File: tb/tb_switch_hit_detector.sv
// Directed bench for switch_hit_detector with DEBOUNCE_CYCLES=4; follows SWITCH_MISS_EN if defined.
module tb_switch_hit_detector;

  logic       clk;
  logic       clr_n;
  logic [7:0] sw;
  logic [7:0] led_state;
  logic       led_step;
  logic [7:0] sw_clean;
  logic       armed;
  logic       hit;
  logic       miss;

  int checks   = 0;
  int failures = 0;

  switch_hit_detector #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .switch    (sw),
    .led_state (led_state),
    .led_step  (led_step),
    .sw_clean  (sw_clean),
    .armed     (armed),
    .hit       (hit),
    .miss      (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Tick n cycles; hit/miss expected only at the given tick index, armed high before arm_drop.
  task automatic run(input string tag, input int n, input int hit_at, input int miss_at,
                     input int arm_drop);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk1({tag, "_hit"}, hit, i == hit_at);
      chk1({tag, "_miss"}, miss, i == miss_at);
      chk1({tag, "_armed"}, armed, i < arm_drop);
    end
  endtask

  task automatic step(input logic [7:0] led);
    led_state = led;
    led_step  = 1'b1;
    tick();
    led_step  = 1'b0;
    chk1("step_armed", armed, 1'b1);
    chk1("step_hit", hit, 1'b0);
  endtask

  initial begin
    clr_n     = 1'b0;
    sw        = 8'hFF;
    led_step  = 1'b0;
    led_state = 8'h00;

    // Reset held with all switches on
    repeat (3) begin
      tick();
      chk8("rst_clean", sw_clean, 8'h00);
      chk1("rst_hit", hit, 1'b0);
      chk1("rst_miss", miss, 1'b0);
      chk1("rst_armed", armed, 1'b0);
    end
    clr_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk8("rel_clean", sw_clean, (i >= 6) ? 8'hFF : 8'h00);
      chk1("rel_hit", hit, 1'b0);
      chk1("rel_miss", miss, 1'b0);
      chk1("rel_armed", armed, 1'b0);
    end

    // Clean restart with switches off
    clr_n = 1'b0;
    sw    = 8'h00;
    tick();
    tick();
    clr_n = 1'b1;
    chk8("rst2_clean", sw_clean, 8'h00);

    // Bounce on switch[2], then hold high
    for (int k = 0; k < 10; k++) begin
      sw[2] = (k % 2 == 0);
      repeat (2) begin
        tick();
        chk8("bounce_clean", sw_clean, 8'h00);
      end
    end
    sw[2] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk8("settle_clean", sw_clean, (i >= 6) ? 8'h04 : 8'h00);
      chk1("settle_hit", hit, 1'b0);
      chk1("settle_miss", miss, 1'b0);
    end

    // Correct flip, then a repeat flip in the same step
    step(8'h08);
    sw[3] = 1'b1;
    run("hit", 8, 7, 0, 7);
    chk8("hit_clean", sw_clean, 8'h0C);
    sw[3] = 1'b0;
    run("hit_again", 8, 0, 0, 0);

    // Wrong flip
    step(8'h08);
    sw[5] = 1'b1;
`ifdef SWITCH_MISS_EN
    run("miss", 8, 0, 7, 7);
`else
    run("wrong", 8, 0, 0, 99);
    sw[3] = 1'b1;
    run("late_hit", 8, 7, 0, 7);
`endif

    // Two bits flipped together
    step(8'h01);
    sw[0] = 1'b1;
    sw[1] = 1'b1;
`ifdef SWITCH_MISS_EN
    run("dual", 8, 0, 7, 7);
`else
    run("dual", 8, 0, 0, 99);
`endif

    // led_step on the same cycle as the sw_clean[0] event
    sw[0] = 1'b0;
`ifdef SWITCH_MISS_EN
    run("coll_pre", 6, 0, 0, 0);
`else
    run("coll_pre", 6, 0, 0, 99);
`endif
    chk1("coll_clean0", sw_clean[0], 1'b0);
    led_state = 8'h01;
    led_step  = 1'b1;
    tick();
    led_step  = 1'b0;
    chk1("coll_hit", hit, 1'b0);
    chk1("coll_miss", miss, 1'b0);
    chk1("coll_armed", armed, 1'b1);
    run("coll_post", 3, 0, 0, 99);
    sw[0] = 1'b1;
    run("coll_hit2", 8, 7, 0, 7);

    // Reset in the middle of a round and a debounce
    step(8'h01);
    sw[0] = 1'b0;
    run("mid", 3, 0, 0, 99);
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    chk1("mid_rst_armed", armed, 1'b0);
    chk8("mid_rst_clean", sw_clean, 8'h00);
    run("mid_reaccept", 8, 0, 0, 0);
    chk8("mid_reaccept_clean", sw_clean, sw);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_hit_detector.md
# switch_hit_detector

Cleans the eight board switches and judges each flip against the currently lit LED, emitting single-cycle `hit` / `miss` pulses. It sits between the raw switch pins plus LED sequencer and the cascaded decimal score counters. `hit` drives the units counter clock directly. The block replaces level-sensitive switch sampling with synchronized, debounced, one-attempt-per-step judging.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a switch change is accepted (≥1; 1 ms at 50 MHz).
- `clk`  in  1: system clock; all logic on rising edge.
- `clr_n`  in  1: reset, synchronous, active-low.
- `switch`  in  8: raw slide switches, asynchronous to `clk`.
- `led_state`  in  8: active LED pattern from the sequencer, nominally one-hot.
- `led_step`  in  1: one-cycle pulse, in `clk` domain, when `led_state` advances to a new LED.
- `sw_clean`  out  8: debounced switch levels.
- `armed`  out  1: high while the current step still accepts an attempt.
- `hit`  out  1: one-cycle pulse for a correct flip; feeds the score counter chain.
- `miss`  out  1: one-cycle pulse for a wrong flip.

## Operation
- **Synchronizer:** two flip-flop stages per bit, giving `sw_sync`.
- **Debounce, per bit:** a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter clears whenever `sw_sync[i] == sw_clean[i]`.
  - Otherwise it increments each cycle.
  - On the cycle it would reach `DEBOUNCE_CYCLES`, `sw_clean[i]` takes `sw_sync[i]` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` never reaches `sw_clean`.
- **Event:** `ev[i]` = `sw_clean[i]` differs from its one-cycle-delayed copy. Both rising and falling flips count, because these are slide switches.
- **States:** IDLE, ARMED, DONE.
  - Reset goes to IDLE.
  - `led_step` in any state goes to ARMED.
  - In IDLE and DONE, events are ignored.
  - In ARMED, an event cycle (`ev != 0`) is judged as follows:
    - `ev` has exactly one bit set, `led_state` is one-hot, and `ev == led_state`: pulse `hit`, go to DONE.
    - Any other nonzero `ev` (wrong bit, several bits at once, or `led_state` zero / multi-hot): pulse `miss`, go to DONE.
- **Simultaneous `led_step` and event:** `led_step` wins. The event is discarded, no pulse is issued, and the state becomes ARMED.
- **`armed`:** equals (state == ARMED).
- **Exclusivity:** `hit` and `miss` are never high together and never high on two consecutive cycles.

## Timing
- **Reset values** (`clr_n` low at a rising edge):
  - `sw_clean` = 8'h00; the synchronizer, delayed copy and debounce counters are also 0.
  - `hit` = 0, `miss` = 0, `armed` = 0, state = IDLE.
- **Reset mid-debounce or mid-round:** pending counts are lost. After reset releases, switches that are on are re-accepted after `DEBOUNCE_CYCLES`. Those re-accepted flips are ignored because the state is IDLE.
- **Latency** from a stable change on `switch[i]`:
  - 2 cycles to `sw_sync`.
  - `DEBOUNCE_CYCLES` cycles to `sw_clean`.
  - `hit` / `miss` registered exactly 1 cycle after the `sw_clean` change.
- **Output widths:** `hit` / `miss` are 1 cycle wide, so each pulse gives exactly one rising edge to the downstream counter.
- **Timing of `armed`:**
  - `armed` rises 1 cycle after `led_step`.
  - `armed` falls in the same cycle the `hit` / `miss` pulse is high.
- **Inputs:** `led_state` is sampled only on the judging cycle. It need not be registered by the sequencer beyond being stable in `clk`.

## Configuration
- **`SWITCH_MISS_EN` defined:** behaviour exactly as above. A wrong flip pulses `miss` and consumes the step.
- **`SWITCH_MISS_EN` undefined:**
  - `miss` is tied to 0.
  - A wrong or ambiguous event in ARMED is ignored and the state stays ARMED.
  - Only a correct single-bit flip ends the step (with `hit`).
  - All other behaviour is unchanged.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4`.
- **Reset:** hold `clr_n`=0 for 3 cycles with `switch`=8'hFF.
  - During reset: all outputs 0.
  - After release: `sw_clean` becomes 8'hFF at cycle 2+4 with no `hit` / `miss` (state IDLE).
- **Bounce rejection:** toggle `switch[2]` high/low every 2 cycles for 20 cycles, then hold high.
  - `sw_clean[2]` changes only 6 cycles after the final edge.
  - No change during bouncing.
- **Hit:** pulse `led_step` with `led_state`=8'h08, then flip `switch[3]`.
  - `hit` high for exactly 1 cycle, 1 cycle after `sw_clean[3]` changes.
  - `armed` drops in that cycle.
  - A second flip of `switch[3]` before the next `led_step` produces nothing.
- **Miss:** `led_state`=8'h08 armed, flip `switch[5]`.
  - With `SWITCH_MISS_EN`: `miss` pulses once, then state is DONE.
  - Without it: no pulse, `armed` stays 1, and a later `switch[3]` flip gives `hit`.
- **Simultaneous flips:** armed with `led_state`=8'h01, flip `switch[0]` and `switch[1]` in the same cycle.
  - Result: `miss` (with macro), no `hit`.
- **`led_step` collision:** make `sw_clean[0]` change on the same cycle as `led_step` with `led_state`=8'h01.
  - No pulse; `armed`=1 next cycle.
  - The next `switch[0]` flip yields `hit`.
